int_ctrl: RTL and testbench

//  Interrupt controller that sits between the external INT pins and the control

---
 rtl/int_ctrl.sv | 139 +++++++++++++
 tb/tb_int_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller between the external INT pins and the CU.
// It synchronises the pins, detects rising edges, latches them as pending and
// applies a per-line mask. It raises one fixed-priority request (lowest index
// wins) and tracks the in-service line through an ack / end-of-interrupt
// handshake.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   int_in_i     async interrupt pins, active high
//   ie_i         global interrupt enable from the CU
//   mask_wr_i    strobe: load mask from mask_din_i
//   mask_din_i   new mask (1 = line enabled)
//   mask_out_o   current mask
//   pending_o    latched, unserviced edges (mask not applied)
//   irq_o        request to the CU (REQ state)
//   irq_vec_o    index of the requested / in-service line
//   irq_ack_i    strobe: CU has taken the interrupt
//   eoi_i        strobe: CU has finished the handler
//   busy_o       high while an interrupt is in service
module int_ctrl #(
  parameter int unsigned N_LINES     = 4,
  parameter int unsigned VEC_W       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_LINES-1:0] int_in_i,
  input  logic               ie_i,
  input  logic               mask_wr_i,
  input  logic [N_LINES-1:0] mask_din_i,
  output logic [N_LINES-1:0] mask_out_o,
  output logic [N_LINES-1:0] pending_o,
  output logic               irq_o,
  output logic [VEC_W-1:0]   irq_vec_o,
  input  logic               irq_ack_i,
  input  logic               eoi_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e                                 state_q, state_d;
  logic [SYNC_STAGES-1:0][N_LINES-1:0]    sync_q;
  logic [N_LINES-1:0]                     sync_prev_q;
  logic [N_LINES-1:0]                     pending_q, pending_d;
  logic [N_LINES-1:0]                     mask_q, mask_d;
  logic [VEC_W-1:0]                       vec_q, vec_d;
  logic                                   irq_q, irq_d;
  logic                                   busy_q, busy_d;

  logic [N_LINES-1:0]                     rise;
  logic [N_LINES-1:0]                     eligible;
  logic [N_LINES-1:0]                     ack_clr;
  logic [VEC_W-1:0]                       winner;

  // Rising edge seen at the output of the synchroniser.
  assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign eligible = pending_q & mask_q;

  // Fixed priority: scanning downward leaves the lowest set index in winner.
  always_comb begin
    winner = '0;
    for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VEC_W'(i);
    end
  end

  // Next state, pending/mask update and registered outputs.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    ack_clr   = '0;

    case (state_q)
      S_IDLE: begin
        if (ie_i && (|eligible)) begin
          state_d = S_REQ;
          vec_d   = winner;
        end
      end
      S_REQ: begin
        // Ack takes precedence over a withdrawal in the same cycle.
        if (irq_ack_i) begin
          state_d = S_SERVICE;
          ack_clr = N_LINES'(1) << vec_q;
        end else if (!ie_i || !mask_q[vec_q]) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (eoi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A coincident edge re-sets the bit being acknowledged.
    pending_d = (pending_q & ~ack_clr) | rise;
    if (mask_wr_i) mask_d = mask_din_i;

    irq_d  = (state_d == S_REQ);
    busy_d = (state_d == S_SERVICE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      sync_prev_q <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      vec_q       <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], int_in_i};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      vec_q       <= vec_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  assign mask_out_o = mask_q;
  assign pending_o  = pending_q;
  assign irq_o      = irq_q;
  assign irq_vec_o  = vec_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model.
module tb_int_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned VW = 2;
  localparam int unsigned S  = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  int_in;
  logic          ie;
  logic          mask_wr;
  logic [N-1:0]  mask_din;
  logic [N-1:0]  mask_out;
  logic [N-1:0]  pending;
  logic          irq;
  logic [VW-1:0] irq_vec;
  logic          irq_ack;
  logic          eoi;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: pin history (index k = input k+1 edges ago), pending, mask,
  // whether a request is outstanding / a line is in service, and the vector.
  logic [N-1:0] hist [S+1];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  bit           m_req;
  bit           m_svc;
  int           m_vec;

  int_ctrl #(.N_LINES(N), .VEC_W(VW), .SYNC_STAGES(S)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .int_in_i   (int_in),
    .ie_i       (ie),
    .mask_wr_i  (mask_wr),
    .mask_din_i (mask_din),
    .mask_out_o (mask_out),
    .pending_o  (pending),
    .irq_o      (irq),
    .irq_vec_o  (irq_vec),
    .irq_ack_i  (irq_ack),
    .eoi_i      (eoi),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [N-1:0] e;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    bit nreq, nsvc;
    int nvec;
    if (rst) begin
      for (int k = 0; k <= int'(S); k++) hist[k] = '0;
      m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_vec = 0;
    end else begin
      // Pin level S edges ago versus S+1 edges ago.
      e = hist[S-1] & ~hist[S];
      for (int k = int'(S); k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int_in;
      clr = '0; nreq = m_req; nsvc = m_svc; nvec = m_vec;
      elig = m_pend & m_mask;
      if (m_req) begin
        if (irq_ack) begin
          clr[m_vec] = 1'b1; nreq = 0; nsvc = 1;
        end else if (!ie || !m_mask[m_vec]) begin
          nreq = 0;
        end
      end else if (m_svc) begin
        if (eoi) nsvc = 0;
      end else if (ie && elig != '0) begin
        nreq = 1;
        for (int i = 0; i < int'(N); i++) begin
          if (elig[i]) begin
            nvec = i;
            break;
          end
        end
      end
      m_pend = (m_pend & ~clr) | e;
      if (mask_wr) m_mask = mask_din;
      m_req = nreq; m_svc = nsvc; m_vec = nvec;
    end
  endtask

  task automatic compare_all();
    check("pending",  32'(pending),  32'(m_pend));
    check("mask_out", 32'(mask_out), 32'(m_mask));
    check("irq",      32'(irq),      32'(m_req));
    check("busy",     32'(busy),     32'(m_svc));
    check("irq_vec",  32'(irq_vec),  32'(m_vec));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic strobe_clear();
    mask_wr = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
  endtask

  int hold;

  initial begin
    rst = 1'b1; int_in = '0; ie = 1'b0; mask_wr = 1'b0; mask_din = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    for (int k = 0; k <= int'(S); k++) hist[k] = '0;
    m_pend = '0; m_mask = '0; m_req = 0; m_svc = 0; m_vec = 0;
    step();
    step();
    rst = 1'b0;
    check("rst_irq",  32'(irq),      32'd0);
    check("rst_mask", 32'(mask_out), 32'd0);

    // Single edge on line 2 with all lines enabled.
    mask_wr = 1'b1; mask_din = 4'b1111; step(); strobe_clear();
    ie = 1'b1; int_in = 4'b0100;
    repeat (3) step();
    int_in = '0;
    check("t1_pend", 32'(pending), 32'b0100);
    check("t1_irq0", 32'(irq), 32'd0);
    step();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_vec", 32'(irq_vec), 32'd2);
    irq_ack = 1'b1; step(); strobe_clear();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_clr",  32'(pending), 32'd0);
    eoi = 1'b1; step(); strobe_clear();
    check("t1_idle", 32'(busy), 32'd0);

    // Masked line stays pending until unmasked.
    mask_wr = 1'b1; mask_din = 4'b0000; step(); strobe_clear();
    int_in = 4'b0001;
    repeat (3) step();
    int_in = '0;
    repeat (2) step();
    check("t3_pend", 32'(pending), 32'b0001);
    check("t3_irq0", 32'(irq), 32'd0);
    mask_wr = 1'b1; mask_din = 4'b0001; step(); strobe_clear();
    step();
    check("t3_irq", 32'(irq), 32'd1);

    // Dropping ie withdraws the request without touching pending.
    ie = 1'b0; step();
    check("t4_irq0", 32'(irq), 32'd0);
    check("t4_pend", 32'(pending[0]), 32'd1);
    ie = 1'b1; step();
    check("t4_irq", 32'(irq), 32'd1);
    irq_ack = 1'b1; step(); strobe_clear();
    check("t4_busy", 32'(busy), 32'd1);

    // Reset while in service.
    mask_wr = 1'b1; mask_din = 4'b1111; step(); strobe_clear();
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_irq",  32'(irq), 32'd0);
    check("t6_pend", 32'(pending), 32'd0);
    check("t6_mask", 32'(mask_out), 32'd0);

    // Randomized traffic; pins are held for at least two cycles.
    mask_wr = 1'b1; mask_din = 4'b1111; step(); strobe_clear();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        int_in = N'($urandom);
        hold = 2 + int'($urandom_range(0, 4));
      end
      hold--;
      ie       = ($urandom_range(0, 7) != 0);
      mask_wr  = ($urandom_range(0, 15) == 0);
      mask_din = N'($urandom);
      irq_ack  = ($urandom_range(0, 2) == 0);
      eoi      = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; strobe_clear();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
